ddr3_config_loader: RTL

- Reads a framed configuration image back from DDR3 and replays its payload as byte writes into a configuration register file.
- Complements the debug uploader (which writes the configuration snapshot into DDR3): this block is the reader/restorer side of the same DDR3 byte-channel handshake.
- Sits between the DDR3 byte-access arbiter and the slot/config tables.
- Validates the frame before asserting a commit pulse.

---
 rtl/ddr3_config_loader_if.sv | 26 ++
 rtl/ddr3_config_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_config_loader_if.sv
// DDR3 byte-channel handshake between a bus master (the loader) and the
// DDR3 byte-access arbiter. The master owns address, request and read strobe;
// the arbiter returns read data and a combined ready / read-data-valid flag.
interface ddr3_config_loader_if;
  logic [27:0] ddr3_addr;
  logic        ddr3_request;
  logic        ddr3_rd;
  logic [7:0]  ddr3_dout;
  logic        ddr3_ready;

  modport master (
    output ddr3_addr,
    output ddr3_request,
    output ddr3_rd,
    input  ddr3_dout,
    input  ddr3_ready
  );

  modport slave (
    input  ddr3_addr,
    input  ddr3_request,
    input  ddr3_rd,
    output ddr3_dout,
    output ddr3_ready
  );
endinterface

// File: rtl/ddr3_config_loader.sv
// Reads a framed configuration image (magic, 16-bit length, payload, 8-bit
// additive checksum) back from DDR3 one byte at a time and replays each payload
// byte as a write into the configuration register file. cfg_commit is pulsed
// only after the whole frame has validated; payload writes made before a
// checksum failure are not undone, so consumers must wait for cfg_commit.
module ddr3_config_loader #(
  parameter logic [27:0] BASE_ADDR = 28'h1400000,
  parameter int          MAX_LEN   = 2048,
  parameter int          ADDR_W    = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  ddr3_config_loader_if.master  ddr,
  output logic                  cfg_wr,
  output logic [ADDR_W-1:0]     cfg_addr,
  output logic [7:0]            cfg_data,
  output logic                  cfg_commit,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error
);

  localparam logic [7:0] MAGIC0 = 8'h4D;
  localparam logic [7:0] MAGIC1 = 8'h58;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WAIT,
    S_ACCEPT,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MAGIC = 2'd1,
    ERR_LEN   = 2'd2,
    ERR_SUM   = 2'd3
  } err_t;

  state_t              state_q, state_n;
  logic [15:0]         offset_q, offset_n;
  logic [15:0]         len_q, len_n;
  logic [7:0]          sum_q, sum_n;
  logic [7:0]          hold_q, hold_n;
  logic [27:0]         addr_q, addr_n;
  logic                req_q, req_n;
  logic                rd_q, rd_n;
  logic                wr_q, wr_n;
  logic [ADDR_W-1:0]   cfg_addr_q, cfg_addr_n;
  logic [7:0]          cfg_data_q, cfg_data_n;
  logic                commit_q, commit_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  err_t                err_q, err_n;

  logic                is_payload;
  logic [7:0]          magic_exp;
  logic [15:0]         len_full;
  logic                advance;

  // Offset falls inside the payload window [4, 4+LEN).
  assign is_payload = (offset_q >= 16'd4) && (offset_q < (len_q + 16'd4));
  assign magic_exp  = offset_q[0] ? MAGIC1 : MAGIC0;
  assign len_full   = {len_q[15:8], hold_q};

  assign ddr.ddr3_addr    = addr_q;
  assign ddr.ddr3_request = req_q;
  assign ddr.ddr3_rd      = rd_q;
  assign cfg_wr           = wr_q;
  assign cfg_addr         = cfg_addr_q;
  assign cfg_data         = cfg_data_q;
  assign cfg_commit       = commit_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = err_q;

  // State and output registers; synchronous reset aborts any load in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      offset_q   <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      hold_q     <= '0;
      addr_q     <= BASE_ADDR;
      req_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      commit_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_n;
      offset_q   <= offset_n;
      len_q      <= len_n;
      sum_q      <= sum_n;
      hold_q     <= hold_n;
      addr_q     <= addr_n;
      req_q      <= req_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      cfg_addr_q <= cfg_addr_n;
      cfg_data_q <= cfg_data_n;
      commit_q   <= commit_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      err_q      <= err_n;
    end
  end

  // Next-state and next-output logic; strobes default low so they last one cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n    = state_q;
    offset_n   = offset_q;
    len_n      = len_q;
    sum_n      = sum_q;
    hold_n     = hold_q;
    addr_n     = addr_q;
    req_n      = req_q;
    rd_n       = 1'b0;
    wr_n       = 1'b0;
    cfg_addr_n = cfg_addr_q;
    cfg_data_n = cfg_data_q;
    commit_n   = 1'b0;
    busy_n     = busy_q;
    done_n     = done_q;
    err_n      = err_q;
    advance    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_n   = 1'b1;
          req_n    = 1'b1;
          offset_n = '0;
          len_n    = '0;
          sum_n    = '0;
          done_n   = 1'b0;
          err_n    = ERR_NONE;
          addr_n   = BASE_ADDR;
          state_n  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (ddr.ddr3_ready) begin
          rd_n    = 1'b1;
          state_n = S_GAP;
        end
      end

      // The responder is still reacting to the read strobe; ready is stale here.
      S_GAP: state_n = S_WAIT;

      S_WAIT: begin
        if (ddr.ddr3_ready) begin
          hold_n = ddr.ddr3_dout;
          // Payload write is registered so it lands in the ACCEPT cycle.
          if (is_payload) begin
            wr_n       = 1'b1;
            cfg_addr_n = ADDR_W'(offset_q - 16'd4);
            cfg_data_n = ddr.ddr3_dout;
          end
          state_n = S_ACCEPT;
        end
      end

      S_ACCEPT: begin
        advance = 1'b1;
        if (offset_q < 16'd2) begin
          if (hold_q != magic_exp) begin
            err_n   = ERR_MAGIC;
            advance = 1'b0;
          end
        end else if (offset_q == 16'd2) begin
          len_n = {hold_q, 8'h00};
        end else if (offset_q == 16'd3) begin
          len_n = len_full;
          if ((len_full == 16'd0) || (len_full > 16'(MAX_LEN))) begin
            err_n   = ERR_LEN;
            advance = 1'b0;
          end
        end else if (is_payload) begin
          sum_n = sum_q + hold_q;
        end else begin
          // Checksum byte at offset 4+LEN terminates the frame.
          if (hold_q != sum_q) err_n = ERR_SUM;
          else                 commit_n = 1'b1;
          advance = 1'b0;
        end

        if (advance) begin
          offset_n = offset_q + 16'd1;
          addr_n   = BASE_ADDR + 28'(offset_q + 16'd1);
          state_n  = S_ISSUE;
        end else begin
          state_n  = S_FINISH;
        end
      end

      S_FINISH: begin
        req_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = (err_q == ERR_NONE);
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
